// File: rtl/t05_phase_sequencer.sv
// Phase sequencer for the team 05 Huffman pipeline: HIST, FLV/HTREE merge loop, CBS, TRN.
// Each phase gets a one-cycle start pulse and is guarded by a watchdog and a merge-count limit.
module t05_phase_sequencer #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned MAX_MERGE = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           fin_code,
  input  logic                 err_in,
  input  logic [TIMEOUT_W-1:0] timeout_lim,
  output logic [2:0]           curr_process,
  output logic                 phase_start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           err_phase,
  output logic [7:0]           merge_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIST  = 3'd1,
    S_FLV   = 3'd2,
    S_HTREE = 3'd3,
    S_CBS   = 3'd4,
    S_TRN   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [7:0] MAX_MERGE_C = 8'(MAX_MERGE);
  localparam logic [3:0] FIN_HIST    = 4'b0001;
  localparam logic [3:0] FIN_PAIR    = 4'b0010;
  localparam logic [3:0] FIN_HTREE   = 4'b0011;
  localparam logic [3:0] FIN_SINGLE  = 4'b0100;
  localparam logic [3:0] FIN_CBS     = 4'b0101;
  localparam logic [3:0] FIN_TRN     = 4'b0110;
  localparam logic [TIMEOUT_W-1:0] WD_ZERO = {TIMEOUT_W{1'b0}};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_next_s;
  state_t               fin_next_s;
  logic                 phase_start_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 error_r;
  logic [2:0]           err_phase_r;
  logic [7:0]           merge_count_r;
  logic [TIMEOUT_W-1:0] wd_r;
  logic                 in_phase_s;
  logic                 wd_expire_s;
  logic                 fin_merge_s;
  logic                 merge_inc_s;
  logic                 run_clear_s;
  logic                 enter_phase_s;
  logic                 enter_err_s;

  function automatic logic is_phase(input state_t s);
    case (s)
      S_HIST, S_FLV, S_HTREE, S_CBS, S_TRN: is_phase = 1'b1;
      default:                              is_phase = 1'b0;
    endcase
  endfunction

  // Destination implied by fin_code for the current phase; unexpected codes go to ERR.
  always_comb begin
    fin_next_s  = S_ERR;
    fin_merge_s = 1'b0;
    case (state_r)
      S_HIST: begin
        if (fin_code == FIN_HIST) fin_next_s = S_FLV;
        else                      fin_next_s = S_ERR;
      end
      S_FLV: begin
        if (fin_code == FIN_PAIR)        fin_next_s = S_HTREE;
        else if (fin_code == FIN_SINGLE) fin_next_s = S_CBS;
        else                             fin_next_s = S_ERR;
      end
      S_HTREE: begin
        // The merge that would exceed the limit is refused, so the count saturates.
        if (fin_code == FIN_HTREE && merge_count_r != MAX_MERGE_C) begin
          fin_next_s  = S_FLV;
          fin_merge_s = 1'b1;
        end else begin
          fin_next_s  = S_ERR;
        end
      end
      S_CBS: begin
        if (fin_code == FIN_CBS) fin_next_s = S_TRN;
        else                     fin_next_s = S_ERR;
      end
      S_TRN: begin
        if (fin_code == FIN_TRN) fin_next_s = S_DONE;
        else                     fin_next_s = S_ERR;
      end
      default: begin
        fin_next_s  = S_ERR;
        fin_merge_s = 1'b0;
      end
    endcase
  end

  // Next-state selection: abort > err_in > watchdog > fin_code > start.
  always_comb begin
    state_next_s = state_r;
    merge_inc_s  = 1'b0;
    run_clear_s  = 1'b0;
    in_phase_s   = is_phase(state_r);
    wd_expire_s  = in_phase_s && (timeout_lim != WD_ZERO) && (wd_r == timeout_lim);
    if (abort) begin
      state_next_s = S_IDLE;
      run_clear_s  = 1'b1;
    end else if (in_phase_s) begin
      if (err_in || wd_expire_s) begin
        state_next_s = S_ERR;
      end else if (!phase_start_r && fin_code != 4'd0) begin
        state_next_s = fin_next_s;
        merge_inc_s  = fin_merge_s;
      end else begin
        state_next_s = state_r;
      end
    end else if (start) begin
      state_next_s = S_HIST;
      run_clear_s  = 1'b1;
    end else begin
      state_next_s = state_r;
    end
    enter_phase_s = is_phase(state_next_s) && (state_next_s != state_r);
    enter_err_s   = (state_next_s == S_ERR) && (state_r != S_ERR);
  end

  // State, registered status outputs, error capture, merge counter and watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      phase_start_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      err_phase_r   <= 3'd0;
      merge_count_r <= 8'd0;
      wd_r          <= WD_ZERO;
    end else begin
      state_r       <= state_next_s;
      phase_start_r <= enter_phase_s;
      busy_r        <= is_phase(state_next_s);
      done_r        <= (state_next_s == S_DONE);
      error_r       <= (state_next_s == S_ERR);
      if (run_clear_s)      err_phase_r <= 3'd0;
      else if (enter_err_s) err_phase_r <= state_r;
      else                  err_phase_r <= err_phase_r;
      if (run_clear_s)      merge_count_r <= 8'd0;
      else if (merge_inc_s) merge_count_r <= merge_count_r + 8'd1;
      else                  merge_count_r <= merge_count_r;
      if (enter_phase_s)    wd_r <= WD_ZERO;
      else if (in_phase_s)  wd_r <= wd_r + WD_ONE;
      else                  wd_r <= WD_ZERO;
    end
  end

  assign curr_process = state_r;
  assign phase_start  = phase_start_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign err_phase    = err_phase_r;
  assign merge_count  = merge_count_r;

endmodule

// File: tb/tb_t05_phase_sequencer.sv
// Self-checking bench for t05_phase_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a transition-table model of the phase sequence.
module tb_t05_phase_sequencer;
  localparam int TW   = 16;
  localparam int MAXM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [3:0]    fin_code;
  logic          err_in;
  logic [TW-1:0] timeout_lim;
  logic [2:0]    curr_process;
  logic          phase_start;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    err_phase;
  logic [7:0]    merge_count;

  int n_checks = 0;
  int n_errors = 0;
  int ps_seen  = 0;
  int route [int];
  int m_state, m_age, m_merges, m_errph;

  t05_phase_sequencer #(.TIMEOUT_W(TW), .MAX_MERGE(MAXM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fin_code(fin_code),
    .err_in(err_in), .timeout_lim(timeout_lim), .curr_process(curr_process),
    .phase_start(phase_start), .busy(busy), .done(done), .error(error),
    .err_phase(err_phase), .merge_count(merge_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, want, $time);
    end
  endtask

  function automatic bit in_run(input int s);
    return (s >= 1) && (s <= 5);
  endfunction

  task automatic model_reset();
    m_state = 0; m_age = 0; m_merges = 0; m_errph = 0;
  endtask

  task automatic m_go(input int s);
    m_state = s; m_age = 0;
  endtask

  task automatic m_err();
    m_errph = m_state; m_state = 7;
  endtask

  // One clock of the reference: route table lookup plus the ordering of overriding events.
  task automatic model_step();
    int key;
    if (!rst) begin model_reset(); return; end
    key = m_state * 16 + int'(fin_code);
    if (abort) begin
      m_go(0); m_merges = 0; m_errph = 0;
    end else if (in_run(m_state)) begin
      if (err_in) m_err();
      else if (timeout_lim != 0 && (m_age % (1 << TW)) == int'(timeout_lim)) m_err();
      else if (m_age != 0 && fin_code != 4'd0) begin
        if (!route.exists(key)) m_err();
        else if (m_state == 3 && m_merges == MAXM) m_err();
        else begin
          if (m_state == 3) m_merges++;
          m_go(route[key]);
        end
      end else m_age++;
    end else if (start) begin
      m_merges = 0; m_errph = 0; m_go(1);
    end
  endtask

  task automatic compare_model();
    chk("curr_process", int'(curr_process), m_state);
    chk("phase_start", int'(phase_start), int'(in_run(m_state) && m_age == 0));
    chk("busy", int'(busy), int'(in_run(m_state)));
    chk("done", int'(done), int'(m_state == 6));
    chk("error", int'(error), int'(m_state == 7));
    chk("err_phase", int'(err_phase), m_errph);
    chk("merge_count", int'(merge_count), m_merges);
    if (phase_start) ps_seen++;
  endtask

  task automatic cyc(input logic s, input logic a, input logic [3:0] f, input logic e);
    start = s; abort = a; fin_code = f; err_in = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
    start = 1'b0; abort = 1'b0; fin_code = 4'd0; err_in = 1'b0;
  endtask

  task automatic idle();       cyc(1'b0, 1'b0, 4'd0, 1'b0); endtask
  task automatic do_start();   cyc(1'b1, 1'b0, 4'd0, 1'b0); endtask
  task automatic do_abort();   cyc(1'b0, 1'b1, 4'd0, 1'b0); endtask
  task automatic phase(input logic [3:0] code);
    idle();
    cyc(1'b0, 1'b0, code, 1'b0);
  endtask

  function automatic logic [3:0] good_code(input int s);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 1; k < 16; k++)
      if (route.exists(s * 16 + k) && (c == 4'd0 || $urandom_range(0, 1) == 1)) c = 4'(k);
    return c;
  endfunction

  initial begin
    route[1*16+1] = 2; route[2*16+2] = 3; route[2*16+4] = 4;
    route[3*16+3] = 2; route[4*16+5] = 5; route[5*16+6] = 6;
    rst = 1'b0; start = 1'b0; abort = 1'b0; err_in = 1'b0; fin_code = 4'd0; timeout_lim = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_curr", int'(curr_process), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_merge", int'(merge_count), 0);
    compare_model();
    rst = 1'b1;
    idle();

    // Full run with three merges.
    ps_seen = 0;
    do_start();
    phase(4'b0001);
    repeat (3) begin phase(4'b0010); phase(4'b0011); end
    phase(4'b0100); phase(4'b0101); phase(4'b0110);
    chk("full_state", int'(curr_process), 6);
    chk("full_merge", int'(merge_count), 3);
    chk("full_done", int'(done), 1);
    chk("full_busy", int'(busy), 0);
    chk("full_pulses", ps_seen, 10);

    // Wrong code in FLV, then restart from ERR.
    do_start(); phase(4'b0001); phase(4'b0101);
    chk("wrong_state", int'(curr_process), 7);
    chk("wrong_error", int'(error), 1);
    chk("wrong_errph", int'(err_phase), 2);
    do_start();
    chk("restart_state", int'(curr_process), 1);
    chk("restart_errph", int'(err_phase), 0);

    // Watchdog on a stalled HTREE: ERR at entry+6.
    timeout_lim = 16'd5;
    phase(4'b0001); phase(4'b0010);
    repeat (5) idle();
    chk("wd_still_htree", int'(curr_process), 3);
    idle();
    chk("wd_state", int'(curr_process), 7);
    chk("wd_errph", int'(err_phase), 3);
    timeout_lim = 16'd0;
    do_abort(); do_start(); phase(4'b0001); phase(4'b0010);
    repeat (40) idle();
    chk("wd_off_state", int'(curr_process), 3);

    // Merge limit reached on the fourth merge.
    do_abort(); do_start(); phase(4'b0001);
    repeat (3) begin phase(4'b0010); phase(4'b0011); end
    phase(4'b0010); phase(4'b0011);
    chk("mlim_state", int'(curr_process), 7);
    chk("mlim_merge", int'(merge_count), MAXM);
    chk("mlim_errph", int'(err_phase), 3);

    // Simultaneous events.
    do_abort(); do_start(); phase(4'b0001);
    idle(); cyc(1'b0, 1'b0, 4'b0010, 1'b1);
    chk("errin_over_fin", int'(curr_process), 7);
    chk("errin_errph", int'(err_phase), 2);
    do_start(); cyc(1'b0, 1'b1, 4'd0, 1'b1);
    chk("abort_over_errin", int'(curr_process), 0);
    do_start(); cyc(1'b0, 1'b0, 4'b0001, 1'b0);
    chk("entry_fin_ignored", int'(curr_process), 1);
    do_start();
    chk("start_busy_ignored", int'(curr_process), 1);
    cyc(1'b0, 1'b0, 4'b0001, 1'b0);
    chk("hist_to_flv", int'(curr_process), 2);

    // Asynchronous reset in CBS after one merge.
    phase(4'b0010); phase(4'b0011); phase(4'b0100);
    chk("cbs_merge", int'(merge_count), 1);
    idle();
    #2 rst = 1'b0;
    #1;
    chk("async_curr", int'(curr_process), 0);
    chk("async_merge", int'(merge_count), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_ps", int'(phase_start), 0);
    model_reset();
    idle();
    rst = 1'b1;
    do_start();
    chk("post_rst_state", int'(curr_process), 1);
    chk("post_rst_merge", int'(merge_count), 0);

    // Randomized traffic biased towards legal codes.
    for (int i = 0; i < 3000; i++) begin
      logic s, a, e;
      logic [3:0] f;
      int r;
      if ($urandom_range(0, 99) < 3)
        timeout_lim = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(2, 12));
      s = ($urandom_range(0, 99) < 15);
      a = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 2);
      r = $urandom_range(0, 99);
      if (r < 50)      f = 4'd0;
      else if (r < 90) f = good_code(m_state);
      else             f = 4'($urandom_range(1, 15));
      cyc(s, a, f, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
